spi_sub_serial: RTL and testbench
=================================

SPI_SUB_SERIAL -- requirements
Module: spi_sub_serial

Interface
REQ-001 SHALL have parameter: LEN, default 4, operand and result width in bits (LEN >= 2).
REQ-002 SHALL have port: i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: i_a  input  LEN  signed minuend (two's complement).
REQ-006 SHALL have port: i_b  input  LEN  signed subtrahend (two's complement).
REQ-007 SHALL have port: o_diff  output  LEN  signed result i_a - i_b, truncated to LEN bits.
REQ-008 SHALL have port: o_carry  output  1  signed overflow flag of the last completed subtraction.
REQ-009 SHALL have port: o_busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-010 SHALL have port: o_done  output  1  one-cycle pulse; o_diff/o_carry valid and new.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE with i_start=1: SHALL capture i_a, i_b into shift registers, clear borrow, clear bit counter, latch sign bits of i_a and i_b, go to SHIFT.
REQ-013 IDLE with i_start=0: SHALL stay in IDLE; registers and outputs hold.
REQ-014 SHIFT: SHALL process one bit per cycle, LSB first: d = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
REQ-015 SHIFT: SHALL shift d into the result register from the MSB side, then shift operand registers right by one.
REQ-016 SHALL leave SHIFT for DONE after exactly LEN SHIFT cycles (counter LEN-1 -> wrap).
REQ-017 DONE: SHALL load o_diff from the result register and set o_carry = (sa != sb) && (result MSB != sa), with sa/sb the latched sign bits.
REQ-018 DONE: SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-019 o_diff/o_carry update only on DONE; SHALL hold the previous result at all other times.
REQ-020 Latency: i_start sampled at edge N -> o_done high in cycle following edge N+LEN+1 (LEN+1 cycles after start); throughput one operation per LEN+2 cycles.
REQ-021 i_start while o_busy=1 (SHIFT or DONE) SHALL be ignored; no queuing, no effect on the running operation.
REQ-022 Changes on i_a/i_b after capture SHALL not affect the running operation.
REQ-023 Final borrow out of the MSB SHALL not drive o_carry; o_carry is signed overflow only.
REQ-024 o_busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.

Reset
REQ-025 i_rst=1 at a rising edge SHALL force IDLE, o_diff=0, o_carry=0, o_done=0, o_busy=0, counter=0, borrow=0, from any state.
REQ-026 Reset mid-operation SHALL abort without producing o_done; i_start while i_rst=1 SHALL be ignored.
REQ-027 First i_start after i_rst deasserts SHALL be accepted normally.

Verification (LEN=4)
REQ-028 i_a=3, i_b=5, pulse i_start -> o_done 5 cycles later, o_diff=4'b1110 (-2), o_carry=0.
REQ-029 i_a=7, i_b=-1 -> o_diff=4'b1000 (-8), o_carry=1; then i_a=-8, i_b=1 -> o_diff=4'b0111 (7), o_carry=1.
REQ-030 i_a=-8, i_b=-8 -> o_diff=0, o_carry=0; i_a=0, i_b=-8 -> o_diff=4'b1000, o_carry=1.
REQ-031 i_start held high continuously with i_a=2, i_b=1 -> o_done pulses every 6 cycles, o_diff=1; operand change during SHIFT does not alter result.
REQ-032 i_rst asserted 2 cycles after i_start -> no o_done, o_diff=0, o_carry=0, o_busy=0 next cycle; new start afterwards yields correct result.
REQ-033 Exhaustive: all 256 (i_a, i_b) pairs -> o_diff equals (i_a - i_b) mod 16, o_carry equals true signed overflow.

Source files
------------

// File: rtl/spi_sub_serial.sv
// Bit-serial two's-complement subtractor: one result bit per clock, LSB first,
// followed by a one-cycle DONE state that publishes the difference and signed overflow.
module spi_sub_serial #(
  parameter int LEN = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic [LEN-1:0] o_diff,
  output logic           o_carry,
  output logic           o_busy,
  output logic           o_done
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [LEN-1:0] a_q, a_d;
  logic [LEN-1:0] b_q, b_d;
  logic [LEN-1:0] res_q, res_d;
  logic [LEN-1:0] diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           brw_q, brw_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           carry_q, carry_d;
  logic           done_q, done_d;

  logic           a0, b0, dBit, brwNext;

  // One full-subtractor slice working on the current LSBs of the operand registers.
  always_comb begin
    a0      = a_q[0];
    b0      = b_q[0];
    dBit    = a0 ^ b0 ^ brw_q;
    brwNext = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          sa_d    = i_a[LEN-1];
          sb_d    = i_b[LEN-1];
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d = {dBit, res_q[LEN-1:1]};
        a_d   = {1'b0, a_q[LEN-1:1]};
        b_d   = {1'b0, b_q[LEN-1:1]};
        brw_d = brwNext;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // Overflow only when the operand signs differ and the result sign departs from the minuend's.
        diff_d  = res_q;
        carry_d = (sa_q != sb_q) && (res_q[LEN-1] != sa_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign o_diff  = diff_q;
  assign o_carry = carry_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_spi_sub_serial.sv
// Self-checking bench for spi_sub_serial: directed corner cases, exhaustive operand sweep
// with random interference, back-to-back starts and mid-operation reset.
module tb_spi_sub_serial;

  localparam int LEN = 4;

  logic           i_clk;
  logic           i_rst;
  logic           i_start;
  logic [LEN-1:0] i_a;
  logic [LEN-1:0] i_b;
  logic [LEN-1:0] o_diff;
  logic           o_carry;
  logic           o_busy;
  logic           o_done;

  int testCount = 0;
  int failCount = 0;

  spi_sub_serial #(.LEN(LEN)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_diff (o_diff),
    .o_carry(o_carry),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // A hung DUT must still end the run with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
    end
  endtask

  // Reference: plain signed integer subtraction, wrapped to LEN bits.
  function automatic logic [LEN-1:0] modelDiff(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int x;
    x = int'($signed(a)) - int'($signed(b));
    return x[LEN-1:0];
  endfunction

  function automatic logic modelOvf(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int x;
    x = int'($signed(a)) - int'($signed(b));
    return (x < -(1 << (LEN - 1))) || (x > (1 << (LEN - 1)) - 1);
  endfunction

  task automatic applyStimulus(input logic [LEN-1:0] a, input logic [LEN-1:0] b, input bit noise);
    int k;
    bit seen;
    logic [LEN-1:0] expDiff;
    logic expOvf;
    expDiff = modelDiff(a, b);
    expOvf  = modelOvf(a, b);
    @(negedge i_clk);
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    checkOutput("busyAfterStart", o_busy, 1);
    seen = 1'b0;
    for (k = 1; k <= LEN + 6; k++) begin
      if (noise) begin
        i_a = LEN'($urandom);
        i_b = LEN'($urandom);
        i_start = (k <= LEN + 1) ? 1'($urandom) : 1'b0;
      end
      @(posedge i_clk);
      #1;
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    checkOutput("doneLatency", seen ? k : 0, LEN + 1);
    checkOutput("diff", o_diff, expDiff);
    checkOutput("carry", o_carry, expOvf);
    checkOutput("busyAtDone", o_busy, 0);
    @(posedge i_clk);
    #1;
    checkOutput("donePulse", o_done, 0);
    checkOutput("diffHold", o_diff, expDiff);
    checkOutput("carryHold", o_carry, expOvf);
  endtask

  initial begin
    int lastDone;
    int doneCount;
    i_rst = 1'b1;
    i_start = 1'b1;
    i_a = '0;
    i_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("resetDiff", o_diff, 0);
    checkOutput("resetCarry", o_carry, 0);
    checkOutput("resetBusy", o_busy, 0);
    checkOutput("resetDone", o_done, 0);
    i_start = 1'b0;
    i_rst = 1'b0;

    applyStimulus(4'd3, 4'd5, 1'b0);
    applyStimulus(4'd7, 4'hF, 1'b0);
    applyStimulus(4'h8, 4'd1, 1'b0);
    applyStimulus(4'h8, 4'h8, 1'b0);
    applyStimulus(4'd0, 4'h8, 1'b0);

    // Start held high: operands are only valid on the cycles where the next edge captures them.
    @(negedge i_clk);
    i_a = 4'd2;
    i_b = 4'd1;
    i_start = 1'b1;
    lastDone = -1;
    doneCount = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        if (lastDone >= 0) checkOutput("holdPeriod", cyc - lastDone, LEN + 2);
        checkOutput("holdDiff", o_diff, 1);
        checkOutput("holdCarry", o_carry, 0);
        lastDone = cyc;
        doneCount++;
      end
      if (o_busy) begin
        i_a = LEN'($urandom);
        i_b = LEN'($urandom);
      end else begin
        i_a = 4'd2;
        i_b = 4'd1;
      end
    end
    checkOutput("holdDoneCount", doneCount >= 4, 1);
    i_start = 1'b0;
    repeat (LEN + 3) @(posedge i_clk);

    // Reset two cycles into an operation aborts it, even with start asserted.
    @(negedge i_clk);
    i_a = 4'd5;
    i_b = 4'd2;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("abortDiff", o_diff, 0);
    checkOutput("abortCarry", o_carry, 0);
    checkOutput("abortBusy", o_busy, 0);
    checkOutput("abortDone", o_done, 0);
    @(posedge i_clk);
    #1;
    checkOutput("rstStartIgnored", o_busy, 0);
    i_rst = 1'b0;
    i_start = 1'b0;
    doneCount = 0;
    for (int cyc = 0; cyc < LEN + 3; cyc++) begin
      @(posedge i_clk);
      #1;
      if (o_done) doneCount++;
    end
    checkOutput("abortNoDone", doneCount, 0);
    applyStimulus(4'd5, 4'd2, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a[LEN-1:0], b[LEN-1:0], 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
